// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported unified RAM between the fetch and memory stages.
// Round-robin on ties, fixed MEM_LAT-cycle access, one-cycle DONE that carries the valid pulse.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  input  logic              i_mem_req,
  input  logic              i_mem_we,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_if_valid,
  output logic [DATA_W-1:0] o_mem_rdata,
  output logic              o_mem_valid,
  output logic              o_stall_if,
  output logic              o_stall_mem,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata
);

  typedef enum logic [1:0] {IDLE, ACC_IF, ACC_MEM, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       last_mem;   // 1: MEM held the most recent grant
  logic       grant_mem;

  // MEM wins when alone, or on a tie when IF was served last.
  assign grant_mem = i_mem_req & (~i_if_req | ~last_mem);

  assign o_stall_if  = i_if_req  & ~o_if_valid;
  assign o_stall_mem = i_mem_req & ~o_mem_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      last_mem    <= 1'b0;
      o_ram_en    <= 1'b0;
      o_ram_we    <= 1'b0;
      o_ram_addr  <= '0;
      o_ram_wdata <= '0;
      o_if_rdata  <= '0;
      o_mem_rdata <= '0;
      o_if_valid  <= 1'b0;
      o_mem_valid <= 1'b0;
    end else begin
      o_if_valid  <= 1'b0;
      o_mem_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_if_req | i_mem_req) begin
            state      <= grant_mem ? ACC_MEM : ACC_IF;
            last_mem   <= grant_mem;
            cnt        <= CNT_INIT;
            o_ram_en   <= 1'b1;
            o_ram_we   <= grant_mem & i_mem_we;
            o_ram_addr <= grant_mem ? i_mem_addr : i_if_addr;
            if (grant_mem) o_ram_wdata <= i_mem_wdata;
          end
        end
        ACC_IF, ACC_MEM: begin
          if (cnt == 4'd0) begin
            state    <= DONE;
            o_ram_en <= 1'b0;
            o_ram_we <= 1'b0;
            if (state == ACC_IF) begin
              o_if_rdata <= i_ram_rdata;
              o_if_valid <= 1'b1;
            end else begin
              if (!o_ram_we) o_mem_rdata <= i_ram_rdata;
              o_mem_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
